cmp_share_arb: RTL and testbench
================================

Name: cmp_share_arb

Overview:
- Shares the single 32-bit register comparator (flags {equal, not-equal, less-than, greater-than, zero}) between two requesters: req0 = branch resolution (ID/EX), req1 = set-on-compare ALU ops.
- Arbitrates round-robin, registers the winning operands onto the comparator, selects one condition bit from the returned flags, and returns a 1-bit result to the winner.
- Sits between the ID/EX pipeline control and the comparator instance.

Parameters:
- WIDTH, 32, operand width; must match the comparator input width.
- SEL_W, 3, condition-select width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- req0_valid  in  1  branch request present.
- req0_ready  out  1  block accepts req0 this cycle.
- req0_a, req0_b  in  WIDTH  branch operands.
- req0_sel  in  SEL_W  condition select.
- req1_valid, req1_ready, req1_a, req1_b, req1_sel  same as req0, for the ALU requester.
- flush  in  1  pipeline flush; cancels an in-flight req0 transaction.
- cmp_in1, cmp_in2  out  WIDTH  registered operands to the comparator.
- cmp_flags  in  5  comparator result: [4] eq, [3] ne, [2] lt, [1] gt, [0] in1==0.
- rsp0_valid, rsp0_result  out  1, 1  response to req0.
- rsp1_valid, rsp1_result  out  1, 1  response to req1.

Behaviour:
- **Reset:** all outputs 0, state IDLE, last_grant=1 (req0 wins the first tie), cmp_in1/cmp_in2=0. Reset taken mid-transaction discards it; no response is issued.
- **FSM IDLE:** reqN_ready = 1 for the granted requester only, and only in IDLE.
  - Grant rule: the only valid requester wins; if both are valid, the one not granted last wins.
  - Handshake on valid & ready: latch a, b, sel and owner; set last_grant=owner; go to CMP.
  - No valid requester: stay in IDLE.
- **FSM CMP:**
  - cmp_in1/cmp_in2 hold the latched operands; both readies are 0.
  - At the clock edge, sample cmp_flags through the sel decode into a result register, then go to RSP.
- **FSM RSP:**
  - rspN_valid=1 for exactly one cycle for the owner; rspN_result holds the registered result.
  - Readies stay 0; the next state is IDLE.
- **Timing:** acceptance at edge N, response visible in the cycle after edge N+2. Latency is 2 cycles; peak throughput is 1 request per 3 cycles.
- **sel decode:**
  - 0 = eq, 1 = ne, 2 = lt, 3 = gt, 4 = zero (a==0).
  - 5 = ge (~lt), 6 = le (~gt), 7 = always (1).
  - The comparator is unsigned.
- **flush:** affects req0 only.
  - Owner req0 in CMP or RSP: return to IDLE and keep rsp0_valid=0.
  - flush in IDLE: blocks a req0 grant that cycle.
  - flush with owner req1: no effect.
- **Simultaneous events:** a new request arriving while busy is held by its requester (valid must stay asserted, payload stable until ready). A response and a new acceptance never occur in the same cycle.
- **cmp_in hold:** cmp_in1/cmp_in2 keep their last value in IDLE to avoid comparator toggling.

Optional Feature:
- **Macro:** CMP_SHARE_STATS_EN.
- **When defined:**
  - Adds outputs stat_grant0, stat_grant1, stat_conflict, 16 bits each. They count completed handshakes per requester, and IDLE cycles with both valids high.
  - Counters saturate at 16'hFFFF and clear on rst.
  - Adds input stat_clr, synchronous, which zeroes all three counters.
- **When undefined:** these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- **Package cmp_share_pkg:**
  - Flag index constants FLAG_EQ=4, FLAG_NE=3, FLAG_LT=2, FLAG_GT=1, FLAG_ZERO=0.
  - SEL_* encodings 0..7.
  - State encoding IDLE/CMP/RSP.
- **Sub-module rr_arb2:** two-input round-robin grant with last_grant register and enable; reused elsewhere for write-port sharing. The sel decode stays inline.

Test Plan:
1. **Single request:** req0 a=5, b=9, sel=2 (lt) → req0_ready=1 at accept; cmp_in1=5, cmp_in2=9 next cycle; rsp0_valid=1, rsp0_result=1 two cycles after accept; rsp1_valid stays 0.
2. **Tie round-robin:** both valid continuously after reset, req1 a=b=7, sel=0 → grant order req0, req1, req0. req1 response result=1. Each response is exactly 3 cycles apart.
3. **Flush cancels a branch:** req0 accepted, flush=1 in the CMP cycle → no rsp0_valid pulse; IDLE next cycle; pending req1 granted the following cycle.
4. **Flush ignores the ALU owner:** req1 accepted, flush=1 during CMP → rsp1_valid=1 at normal latency.
5. **sel sweep:** a=0, b=0 over sel 0..7 → results 1, 0, 0, 0, 1, 1, 1, 1. With a=3, b=2: results 0, 1, 0, 1, 0, 1, 0, 1.
6. **Reset mid-operation:** rst=1 during RSP → rsp valids 0 next cycle; outputs return to reset values. With CMP_SHARE_STATS_EN, counters read 0; after 3 accepted req0 transactions, stat_grant0=3.

Source files
------------

// File: rtl/cmp_share_pkg.sv
// Shared constants for the comparator-sharing arbiter: comparator flag bit
// positions, condition-select encodings and the arbiter FSM state encoding.
package cmp_share_pkg;

  // Bit positions inside the 5-bit flag word returned by the comparator
  localparam int FLAG_EQ   = 4;
  localparam int FLAG_NE   = 3;
  localparam int FLAG_LT   = 2;
  localparam int FLAG_GT   = 1;
  localparam int FLAG_ZERO = 0;
  localparam int NUM_FLAGS = 5;

  // Condition-select encodings; the comparator is unsigned
  localparam logic [2:0] SEL_EQ     = 3'd0;
  localparam logic [2:0] SEL_NE     = 3'd1;
  localparam logic [2:0] SEL_LT     = 3'd2;
  localparam logic [2:0] SEL_GT     = 3'd3;
  localparam logic [2:0] SEL_ZERO   = 3'd4;
  localparam logic [2:0] SEL_GE     = 3'd5;
  localparam logic [2:0] SEL_LE     = 3'd6;
  localparam logic [2:0] SEL_ALWAYS = 3'd7;

  // Width of each optional statistics counter
  localparam int STAT_W = 16;

  // Arbiter FSM: accept in IDLE, drive comparator in CMP, respond in RSP
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RSP  = 2'd2
  } state_t;

endpackage

// File: rtl/cmp_share_arb_rr_arb2.sv
// Two-input round-robin grant generator. The grant is combinational on the
// request vector; the last-grant memory only advances when the caller says a
// grant was actually consumed (en high while some grant is asserted).
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  // 1 means requester 1 was granted last, so requester 0 wins the next tie
  logic last_grant_reg;

  // Remember who was served last, only when a grant was taken
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_reg <= 1'b1;
    end else if (en && (grant != 2'b00)) begin
      last_grant_reg <= grant[1];
    end
  end

  // Sole requester wins; on a tie the one not served last wins
  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_reg ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/cmp_share_arb.sv
// Shares one unsigned register comparator between the branch requester
// (req0) and the set-on-compare ALU requester (req1). A request is accepted
// in IDLE, its operands are registered onto the comparator for one CMP
// cycle, the selected condition bit is captured at the end of CMP and
// returned to the owner for exactly one RSP cycle. flush cancels only
// branch-owned transactions.
// Optional build macro CMP_SHARE_STATS_EN adds saturating grant/conflict
// counters and a synchronous stat_clr input.
module cmp_share_arb
  import cmp_share_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEL_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [SEL_W-1:0] req0_sel,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [SEL_W-1:0] req1_sel,
  input  logic             flush,
  output logic [WIDTH-1:0] cmp_in1,
  output logic [WIDTH-1:0] cmp_in2,
  input  logic [NUM_FLAGS-1:0] cmp_flags,
  output logic             rsp0_valid,
  output logic             rsp0_result,
  output logic             rsp1_valid,
`ifdef CMP_SHARE_STATS_EN
  input  logic             stat_clr,
  output logic [STAT_W-1:0] stat_grant0,
  output logic [STAT_W-1:0] stat_grant1,
  output logic [STAT_W-1:0] stat_conflict,
`endif
  output logic             rsp1_result
);

  genvar gi;

  state_t           state_reg;
  state_t           state_next;
  logic             owner_reg;     // 0 = branch requester, 1 = ALU requester
  logic [SEL_W-1:0] sel_reg;
  logic [WIDTH-1:0] cmp_in1_reg;
  logic [WIDTH-1:0] cmp_in2_reg;
  logic             result_reg;

  logic [1:0] valid_vec;
  logic [1:0] arb_req;
  logic [1:0] grant;
  logic [1:0] ready_vec;
  logic [1:0] hs_vec;
  logic       idle_open;
  logic       hs_any;
  logic       sel_bit;

  // Acceptance is only possible in IDLE and never while reset is asserted
  assign idle_open = (state_reg == ST_IDLE) && !rst;
  assign valid_vec = {req1_valid, req0_valid};
  // A flush in IDLE hides the branch request from the arbiter for that cycle
  assign arb_req   = {req1_valid, req0_valid & ~flush};

  rr_arb2 u_arb (
    .clk   (clk),
    .rst   (rst),
    .req   (arb_req),
    .en    (idle_open),
    .grant (grant)
  );

  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      assign ready_vec[gi] = grant[gi] & idle_open;
      assign hs_vec[gi]    = ready_vec[gi] & valid_vec[gi];
    end
  endgenerate

  assign hs_any     = |hs_vec;
  assign req0_ready = ready_vec[0];
  assign req1_ready = ready_vec[1];
  assign cmp_in1    = cmp_in1_reg;
  assign cmp_in2    = cmp_in2_reg;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM next-state: a flushed branch transaction drops straight back to IDLE
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (hs_any) begin
          state_next = ST_CMP;
        end
      end
      ST_CMP: begin
        if (!owner_reg && flush) begin
          state_next = ST_IDLE;
        end else begin
          state_next = ST_RSP;
        end
      end
      ST_RSP:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // FSM outputs: one-cycle response to the owner, suppressed by flush for req0
  always_comb begin
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    if ((state_reg == ST_RSP) && !rst) begin
      if (owner_reg) begin
        rsp1_valid = 1'b1;
      end else begin
        rsp0_valid = !flush;
      end
    end
    rsp0_result = rsp0_valid & result_reg;
    rsp1_result = rsp1_valid & result_reg;
  end

  // Condition decode of the comparator flags for the latched select
  always_comb begin
    sel_bit = 1'b0;
    case (sel_reg)
      SEL_EQ:     sel_bit = cmp_flags[FLAG_EQ];
      SEL_NE:     sel_bit = cmp_flags[FLAG_NE];
      SEL_LT:     sel_bit = cmp_flags[FLAG_LT];
      SEL_GT:     sel_bit = cmp_flags[FLAG_GT];
      SEL_ZERO:   sel_bit = cmp_flags[FLAG_ZERO];
      SEL_GE:     sel_bit = ~cmp_flags[FLAG_LT];
      SEL_LE:     sel_bit = ~cmp_flags[FLAG_GT];
      SEL_ALWAYS: sel_bit = 1'b1;
      default:    sel_bit = 1'b0;
    endcase
  end

  // Datapath: latch winner payload on handshake, capture result at end of CMP.
  // Operands are only rewritten on a handshake so the comparator inputs stay
  // quiet while idle.
  always_ff @(posedge clk) begin
    if (rst) begin
      owner_reg   <= 1'b0;
      sel_reg     <= '0;
      cmp_in1_reg <= '0;
      cmp_in2_reg <= '0;
      result_reg  <= 1'b0;
    end else begin
      if (hs_any) begin
        owner_reg   <= hs_vec[1];
        sel_reg     <= hs_vec[1] ? req1_sel : req0_sel;
        cmp_in1_reg <= hs_vec[1] ? req1_a   : req0_a;
        cmp_in2_reg <= hs_vec[1] ? req1_b   : req0_b;
      end
      if (state_reg == ST_CMP) begin
        result_reg <= sel_bit;
      end
    end
  end

`ifdef CMP_SHARE_STATS_EN
  // Counter order: [0] req0 handshakes, [1] req1 handshakes, [2] IDLE ties
  logic [2:0]          stat_inc;
  logic [3*STAT_W-1:0] stat_flat;

  assign stat_inc = {idle_open & req0_valid & req1_valid, hs_vec};

  generate
    for (gi = 0; gi < 3; gi++) begin : g_stat
      logic [STAT_W-1:0] cnt_reg;

      // Saturating event counter with synchronous clear
      always_ff @(posedge clk) begin
        if (rst || stat_clr) begin
          cnt_reg <= '0;
        end else if (stat_inc[gi] && (cnt_reg != {STAT_W{1'b1}})) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign stat_flat[gi*STAT_W +: STAT_W] = cnt_reg;
    end
  endgenerate

  assign stat_grant0   = stat_flat[0*STAT_W +: STAT_W];
  assign stat_grant1   = stat_flat[1*STAT_W +: STAT_W];
  assign stat_conflict = stat_flat[2*STAT_W +: STAT_W];
`endif

endmodule

// File: tb/tb_cmp_share_arb.sv
// Scoreboard bench for cmp_share_arb: drivers push the expected result and
// acceptance cycle at each handshake; a monitor pops and compares on every
// response pulse. Also honours CMP_SHARE_STATS_EN when defined.
module tb_cmp_share_arb;
  import cmp_share_pkg::*;

  localparam int WIDTH = 32;
  localparam int SEL_W = 3;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0_valid, req0_ready;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic [SEL_W-1:0] req0_sel;
  logic             req1_valid, req1_ready;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic [SEL_W-1:0] req1_sel;
  logic             flush;
  logic [WIDTH-1:0] cmp_in1, cmp_in2;
  logic [4:0]       cmp_flags;
  logic             rsp0_valid, rsp0_result, rsp1_valid, rsp1_result;
`ifdef CMP_SHARE_STATS_EN
  logic             stat_clr;
  logic [15:0]      stat_grant0, stat_grant1, stat_conflict;
`endif

  cmp_share_arb #(.WIDTH(WIDTH), .SEL_W(SEL_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req0_valid  (req0_valid),
    .req0_ready  (req0_ready),
    .req0_a      (req0_a),
    .req0_b      (req0_b),
    .req0_sel    (req0_sel),
    .req1_valid  (req1_valid),
    .req1_ready  (req1_ready),
    .req1_a      (req1_a),
    .req1_b      (req1_b),
    .req1_sel    (req1_sel),
    .flush       (flush),
    .cmp_in1     (cmp_in1),
    .cmp_in2     (cmp_in2),
    .cmp_flags   (cmp_flags),
    .rsp0_valid  (rsp0_valid),
    .rsp0_result (rsp0_result),
    .rsp1_valid  (rsp1_valid),
`ifdef CMP_SHARE_STATS_EN
    .stat_clr      (stat_clr),
    .stat_grant0   (stat_grant0),
    .stat_grant1   (stat_grant1),
    .stat_conflict (stat_conflict),
`endif
    .rsp1_result (rsp1_result)
  );

  always #5 clk = ~clk;

  // Stand-in for the shared unsigned comparator
  assign cmp_flags = {cmp_in1 == cmp_in2, cmp_in1 != cmp_in2,
                      cmp_in1 < cmp_in2, cmp_in1 > cmp_in2, cmp_in1 == '0};

  typedef struct {
    logic res;
    int   acc;
  } exp_t;

  exp_t exp_q0[$];
  exp_t exp_q1[$];
  int   grant_log[$];
  int   acc_log[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   rsp_cnt0 = 0;
  int   rsp_cnt1 = 0;
  int   last_acc0 = 0;
  int   last_acc1 = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Response monitor / scoreboard
  always @(negedge clk) begin
    exp_t e;
    if (rsp0_valid) begin
      rsp_cnt0++;
      checks++;
      if (exp_q0.size() == 0) begin
        failures++;
        $display("FAIL rsp0_unexpected got result=%0d at cycle %0d expected no response", rsp0_result, cyc);
      end else begin
        e = exp_q0.pop_front();
        if (rsp0_result !== e.res || (cyc - e.acc) != 2) begin
          failures++;
          $display("FAIL rsp0 got result=%0d latency=%0d expected result=%0d latency=2", rsp0_result, cyc - e.acc, e.res);
        end else begin
          $display("rsp port=0 result=%0d cycle=%0d", rsp0_result, cyc);
        end
      end
    end
    if (rsp1_valid) begin
      rsp_cnt1++;
      checks++;
      if (exp_q1.size() == 0) begin
        failures++;
        $display("FAIL rsp1_unexpected got result=%0d at cycle %0d expected no response", rsp1_result, cyc);
      end else begin
        e = exp_q1.pop_front();
        if (rsp1_result !== e.res || (cyc - e.acc) != 2) begin
          failures++;
          $display("FAIL rsp1 got result=%0d latency=%0d expected result=%0d latency=2", rsp1_result, cyc - e.acc, e.res);
        end else begin
          $display("rsp port=1 result=%0d cycle=%0d", rsp1_result, cyc);
        end
      end
    end
  end

  // Drive one request and hold it until accepted; call at posedge+#1
  task automatic send(input int port, input logic [31:0] a, input logic [31:0] b,
                      input logic [2:0] sel, input logic res, input bit expect_rsp);
    int   n = 0;
    logic rdy;
    exp_t e;
    if (port == 0) begin
      req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = sel;
    end else begin
      req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = sel;
    end
    do begin
      @(negedge clk);
      n++;
      rdy = (port == 0) ? req0_ready : req1_ready;
    end while (!rdy && n < 60);
    checks++;
    if (!rdy) begin
      failures++;
      $display("FAIL handshake_timeout port=%0d got ready=0 expected ready=1 within 60 cycles", port);
    end else begin
      $display("accept port=%0d a=%0d b=%0d sel=%0d cycle=%0d", port, a, b, sel, cyc);
      if (port == 0) last_acc0 = cyc; else last_acc1 = cyc;
      grant_log.push_back(port);
      acc_log.push_back(cyc);
      if (expect_rsp) begin
        e.res = res;
        e.acc = cyc;
        if (port == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
      end
    end
    @(posedge clk);
    #1;
    if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp_zero;
    logic [7:0] exp_32;
    int         c0;
    int         c1;

    rst = 1'b1; flush = 1'b0;
    req0_valid = 1'b1; req0_a = 32'd1; req0_b = 32'd2; req0_sel = SEL_LT;
    req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = '0;
`ifdef CMP_SHARE_STATS_EN
    stat_clr = 1'b0;
`endif
    // Reset state: no acceptance and all outputs low while reset is held
    @(negedge clk);
    @(negedge clk);
    check("reset_ready0", {31'd0, req0_ready}, 32'd0);
    check("reset_rsp0", {31'd0, rsp0_valid}, 32'd0);
    check("reset_cmp_in1", cmp_in1, 32'd0);
    check("reset_cmp_in2", cmp_in2, 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_ready1", {31'd0, req1_ready}, 32'd0);
    @(posedge clk); #1;

    // Single branch request: 5 < 9
    c1 = rsp_cnt1;
    send(0, 32'd5, 32'd9, SEL_LT, 1'b1, 1'b1);
    @(negedge clk);
    check("single_cmp_in1", cmp_in1, 32'd5);
    check("single_cmp_in2", cmp_in2, 32'd9);
    check("single_ready0_busy", {31'd0, req0_ready}, 32'd0);
    idle(4);
    check("single_no_rsp1", 32'(rsp_cnt1), 32'(c1));

    // Tie round-robin right after reset: order 0,1,0, three cycles apart
    do_reset();
    grant_log.delete();
    acc_log.delete();
    fork
      begin
        send(0, 32'd10, 32'd3, SEL_GT, 1'b1, 1'b1);
        send(0, 32'd10, 32'd3, SEL_LE, 1'b0, 1'b1);
      end
      send(1, 32'd7, 32'd7, SEL_EQ, 1'b1, 1'b1);
    join
    idle(4);
    check("rr_len", 32'(grant_log.size()), 32'd3);
    if (grant_log.size() == 3) begin
      check("rr_grant_first", 32'(grant_log[0]), 32'd0);
      check("rr_grant_second", 32'(grant_log[1]), 32'd1);
      check("rr_grant_third", 32'(grant_log[2]), 32'd0);
      check("rr_spacing_a", 32'(acc_log[1] - acc_log[0]), 32'd3);
      check("rr_spacing_b", 32'(acc_log[2] - acc_log[1]), 32'd3);
    end

    // Flush in CMP cancels a branch; pending ALU request granted next IDLE
    c0 = rsp_cnt0;
    send(0, 32'd1, 32'd2, SEL_LT, 1'b1, 1'b0);
    flush = 1'b1;
    fork
      send(1, 32'd4, 32'd4, SEL_NE, 1'b0, 1'b1);
      begin
        @(posedge clk); #1;
        flush = 1'b0;
      end
    join
    idle(4);
    check("flush_no_rsp0", 32'(rsp_cnt0), 32'(c0));
    check("flush_req1_gap", 32'(last_acc1 - last_acc0), 32'd2);

    // Flush while the ALU owns the comparator has no effect
    c1 = rsp_cnt1;
    send(1, 32'd2, 32'd8, SEL_LT, 1'b1, 1'b1);
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    idle(3);
    check("flush_alu_rsp1", 32'(rsp_cnt1 - c1), 32'd1);

    // Flush held in IDLE blocks a branch grant
    req0_valid = 1'b1; req0_a = 32'd0; req0_b = 32'd0; req0_sel = SEL_EQ;
    flush = 1'b1;
    @(negedge clk);
    check("flush_idle_block", {31'd0, req0_ready}, 32'd0);
    @(posedge clk); #1;
    flush = 1'b0;
    req0_valid = 1'b0;

    // Condition select sweep
    exp_zero = 8'b1111_0001;
    exp_32   = 8'b1010_1010;
    for (int s = 0; s < 8; s++) begin
      send(0, 32'd0, 32'd0, 3'(s), exp_zero[s], 1'b1);
    end
    for (int s = 0; s < 8; s++) begin
      send(1, 32'd3, 32'd2, 3'(s), exp_32[s], 1'b1);
    end
    idle(4);

    // Reset during RSP discards the response
    c0 = rsp_cnt0;
    send(0, 32'd9, 32'd9, SEL_EQ, 1'b1, 1'b0);
    idle(1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_rsp0", {31'd0, rsp0_valid}, 32'd0);
    check("rstmid_rsp1", {31'd0, rsp1_valid}, 32'd0);
    check("rstmid_cmp_in1", cmp_in1, 32'd0);
    check("rstmid_cmp_in2", cmp_in2, 32'd0);
    @(posedge clk); #1;
    idle(3);
    check("rstmid_no_rsp0", 32'(rsp_cnt0), 32'(c0));
`ifdef CMP_SHARE_STATS_EN
    check("stat_grant0_zero", 32'(stat_grant0), 32'd0);
    check("stat_conflict_zero", 32'(stat_conflict), 32'd0);
    for (int k = 0; k < 3; k++) begin
      send(0, 32'(k), 32'd1, SEL_GE, (k >= 1) ? 1'b1 : 1'b0, 1'b1);
    end
    idle(4);
    check("stat_grant0_three", 32'(stat_grant0), 32'd3);
    check("stat_grant1_zero", 32'(stat_grant1), 32'd0);
`endif

    idle(4);
    check("queue0_drained", 32'(exp_q0.size()), 32'd0);
    check("queue1_drained", 32'(exp_q1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
